// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared types and helpers for the fractal-sync control node
package fractal_sync_pkg;

  localparam int unsigned FSYNC_LVL_W = 4;
  localparam int unsigned FSYNC_ID_W  = 4;

  typedef enum logic [1:0] {
    FSYNC_ERR_LVL = 2'd0,
    FSYNC_ERR_ID  = 2'd1,
    FSYNC_ERR_DUP = 2'd2
  } fsync_ccn_err_e;

  // Default-width request/response records; the node itself is width-parameterised.
  typedef struct packed {
    logic [FSYNC_LVL_W-1:0] level;
    logic [FSYNC_ID_W-1:0]  id;
  } fsync_req_t;

  typedef struct packed {
    logic [FSYNC_LVL_W-1:0] level;
    logic [FSYNC_ID_W-1:0]  id;
  } fsync_rsp_t;

  function automatic int unsigned fsync_wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// rtl/fractal_sync_fifo.sv - valid/ready FIFO with full/empty tracking, no bypass
module fractal_sync_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i && !full;
  assign pop         = out_ready_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = PTR_W'(fsync_wrap_inc(32'(wr_ptr_q), DEPTH));
    if (pop)  rd_ptr_d = PTR_W'(fsync_wrap_inc(32'(rd_ptr_q), DEPTH));
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/fractal_sync_ccn.sv
// rtl/fractal_sync_ccn.sv - fractal-sync tree node: child FIFOs, RR arbiter, arrival RF, forward/response paths
module fractal_sync_ccn
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_IN_PORTS  = 2,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned LVL_W       = FSYNC_LVL_W,
  parameter int unsigned ID_W        = FSYNC_ID_W,
  parameter int unsigned NODE_LVL    = 1,
  parameter int unsigned N_ROOT_REGS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_IN_PORTS-1:0]         req_valid_i,
  output logic [N_IN_PORTS-1:0]         req_ready_o,
  input  logic [N_IN_PORTS*LVL_W-1:0]   req_level_i,
  input  logic [N_IN_PORTS*ID_W-1:0]    req_id_i,
  output logic                          rsp_valid_o,
  output logic [LVL_W-1:0]              rsp_level_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic                          up_req_valid_o,
  input  logic                          up_req_ready_i,
  output logic [LVL_W-1:0]              up_req_level_o,
  output logic [ID_W-1:0]               up_req_id_o,
  input  logic                          up_rsp_valid_i,
  input  logic [LVL_W-1:0]              up_rsp_level_i,
  input  logic [ID_W-1:0]               up_rsp_id_i,
  output logic                          err_o,
  output logic [1:0]                    err_code_o,
  output logic [$clog2(N_IN_PORTS)-1:0] err_port_o
);

  localparam int unsigned PORT_W = $clog2(N_IN_PORTS);
  localparam int unsigned REQ_W  = LVL_W + ID_W;

  logic [N_IN_PORTS-1:0] fifo_valid, fifo_pop, is_fwd, eligible;
  logic [REQ_W-1:0]      fifo_data  [N_IN_PORTS];
  logic [LVL_W-1:0]      head_level [N_IN_PORTS];
  logic [ID_W-1:0]       head_id    [N_IN_PORTS];

  logic                  out_free;
  logic                  gnt_valid;
  logic [PORT_W-1:0]     gnt_port;
  logic [LVL_W-1:0]      gnt_level;
  logic [ID_W-1:0]       gnt_id;

  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_IN_PORTS-1:0] rf_q [N_ROOT_REGS];
  logic [N_IN_PORTS-1:0] rf_d [N_ROOT_REGS];

  logic                  up_vld_q, up_vld_d;
  logic [LVL_W-1:0]      up_level_q, up_level_d;
  logic [ID_W-1:0]       up_id_q, up_id_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [LVL_W-1:0]      rsp_level_q, rsp_level_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  err_q, err_d;
  fsync_ccn_err_e        err_code_q, err_code_d;
  logic [PORT_W-1:0]     err_port_q, err_port_d;

  for (genvar p = 0; p < N_IN_PORTS; p++) begin : g_port
    fractal_sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (req_valid_i[p]),
      .in_ready_o  (req_ready_o[p]),
      .in_data_i   ({req_level_i[p*LVL_W +: LVL_W], req_id_i[p*ID_W +: ID_W]}),
      .out_valid_o (fifo_valid[p]),
      .out_ready_i (fifo_pop[p]),
      .out_data_o  (fifo_data[p])
    );

    assign head_level[p] = fifo_data[p][REQ_W-1 -: LVL_W];
    assign head_id[p]    = fifo_data[p][ID_W-1:0];
    assign is_fwd[p]     = head_level[p] > LVL_W'(NODE_LVL);
    assign eligible[p]   = fifo_valid[p] && !up_rsp_valid_i && (!is_fwd[p] || out_free);
    assign fifo_pop[p]   = gnt_valid && (gnt_port == PORT_W'(p));
  end

  // A forward head may only win if the out register is free or handing off this cycle.
  assign out_free  = !up_vld_q || up_req_ready_i;
  assign gnt_level = head_level[gnt_port];
  assign gnt_id    = head_id[gnt_port];

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_port  = '0;
    for (int unsigned i = 0; i < N_IN_PORTS; i++) begin
      idx = (32'(rr_ptr_q) + i) % N_IN_PORTS;
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_port  = PORT_W'(idx);
      end
    end
    rr_ptr_d = gnt_valid ? PORT_W'(fsync_wrap_inc(32'(gnt_port), N_IN_PORTS)) : rr_ptr_q;
  end

  always_comb begin
    rf_d        = rf_q;
    up_vld_d    = up_vld_q && !up_req_ready_i;
    up_level_d  = up_level_q;
    up_id_d     = up_id_q;
    rsp_vld_d   = 1'b0;
    rsp_level_d = rsp_level_q;
    rsp_id_d    = rsp_id_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    err_port_d  = err_port_q;

    if (up_rsp_valid_i) begin
      rsp_vld_d   = 1'b1;
      rsp_level_d = up_rsp_level_i;
      rsp_id_d    = up_rsp_id_i;
    end

    if (gnt_valid) begin
      if (gnt_level > LVL_W'(NODE_LVL)) begin
        up_vld_d   = 1'b1;
        up_level_d = gnt_level;
        up_id_d    = gnt_id;
      end else if (gnt_level < LVL_W'(NODE_LVL)) begin
        err_d      = 1'b1;
        err_code_d = FSYNC_ERR_LVL;
        err_port_d = gnt_port;
      end else if (32'(gnt_id) >= N_ROOT_REGS) begin
        err_d      = 1'b1;
        err_code_d = FSYNC_ERR_ID;
        err_port_d = gnt_port;
      end else begin
        for (int unsigned r = 0; r < N_ROOT_REGS; r++) begin
          if (32'(gnt_id) == r) begin
            if (rf_q[r][gnt_port]) begin
              err_d      = 1'b1;
              err_code_d = FSYNC_ERR_DUP;
              err_port_d = gnt_port;
            end else begin
              rf_d[r][gnt_port] = 1'b1;
              // Last arrival completes the barrier and frees the slot in the same edge.
              if (&rf_d[r]) begin
                rf_d[r]     = '0;
                rsp_vld_d   = 1'b1;
                rsp_level_d = LVL_W'(NODE_LVL);
                rsp_id_d    = gnt_id;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      for (int unsigned r = 0; r < N_ROOT_REGS; r++) rf_q[r] <= '0;
      up_vld_q    <= 1'b0;
      up_level_q  <= '0;
      up_id_q     <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_level_q <= '0;
      rsp_id_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= FSYNC_ERR_LVL;
      err_port_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rf_q        <= rf_d;
      up_vld_q    <= up_vld_d;
      up_level_q  <= up_level_d;
      up_id_q     <= up_id_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_level_q <= rsp_level_d;
      rsp_id_q    <= rsp_id_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_port_q  <= err_port_d;
    end
  end

  assign up_req_valid_o = up_vld_q;
  assign up_req_level_o = up_level_q;
  assign up_req_id_o    = up_id_q;
  assign rsp_valid_o    = rsp_vld_q;
  assign rsp_level_o    = rsp_level_q;
  assign rsp_id_o       = rsp_id_q;
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;
  assign err_port_o     = err_port_q;

endmodule

// File: doc/fractal_sync_ccn.md
Name: fractal_sync_ccn

Overview:
Generalised fractal-sync core control for one tree node. It serves N_IN_PORTS child request channels, each buffered in its own FIFO of depth FIFO_DEPTH, and picks among them with a round-robin arbiter. A request at this node's level is merged in a per-barrier arrival register file; a request at a higher level is forwarded to the parent port. Responses, whether from local completion or from the parent, are broadcast to all children, and protocol errors are reported.

Parameters:
N_IN_PORTS, 2, number of child request/response channels (>=2)
FIFO_DEPTH, 2, entries per input FIFO (>=1)
LVL_W, 4, width of the sync-level field
ID_W, 4, width of the barrier-id field
NODE_LVL, 1, tree level this node completes locally
N_ROOT_REGS, 8, arrival registers, one per barrier id (<= 2**ID_W)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  N_IN_PORTS  child request valid
req_ready_o  out  N_IN_PORTS  child request ready (= FIFO not full)
req_level_i  in  N_IN_PORTS*LVL_W  requested sync level per child
req_id_i  in  N_IN_PORTS*ID_W  barrier id per child
rsp_valid_o  out  1  response pulse, broadcast to all children
rsp_level_o  out  LVL_W  response level
rsp_id_o  out  ID_W  response barrier id
up_req_valid_o  out  1  forwarded request valid
up_req_ready_i  in  1  parent ready
up_req_level_o  out  LVL_W  forwarded level
up_req_id_o  out  ID_W  forwarded id
up_rsp_valid_i  in  1  parent response pulse (no backpressure)
up_rsp_level_i  in  LVL_W  parent response level
up_rsp_id_i  in  ID_W  parent response id
err_o  out  1  one-cycle error pulse
err_code_o  out  2  0 level<NODE_LVL, 1 id>=N_ROOT_REGS, 2 duplicate arrival
err_port_o  out  $clog2(N_IN_PORTS)  offending child index

Behaviour:
- Reset, sampled on the clk_i edge while rst_i=1: FIFOs empty, RF all zero, RR pointer 0. All outputs 0 except req_ready_o, which is all-ones after reset. Reset mid-operation drops every in-flight request and pending arrival.
- Input: push happens on req_valid_i&req_ready_o. req_ready_o = !full; there is no same-cycle bypass, so a full FIFO stays not-ready even while it is being popped.
- Arbitration: each cycle at most one head is granted.
  - Eligible: FIFO non-empty AND up_rsp_valid_i=0 AND (the head is a local request OR the out register is empty or draining this cycle).
  - Grant goes to the first eligible port at or after the pointer; the pointer then moves to grant+1 mod N_IN_PORTS.
  - Non-eligible heads do not block other ports.
- Classification of the granted head:
  - level>NODE_LVL: forward. The out register loads {level,id}; up_req_valid_o rises the next cycle and holds its value until up_req_ready_i.
  - level==NODE_LVL: local. id>=N_ROOT_REGS gives err code 1 and the request is dropped. If bit[port] of RF[id] is already set, err code 2 and drop. Otherwise set the bit.
  - level<NODE_LVL: err code 0, dropped.
  - Errors pulse one cycle after the grant.
- Local completion: when RF[id] reaches all-ones after the set, RF[id] clears in the same edge. rsp_valid_o pulses the next cycle with {NODE_LVL,id}.
- Parent response: up_rsp_valid_i at cycle t gives rsp_valid_o at t+1 with the parent's level and id. Arbitration is suppressed at t, so responses never collide.
- Latency:
  - Push at t, grant at t+1, rsp_valid_o or up_req_valid_o at t+2.
  - Throughput is one grant per cycle.
- Only rsp_valid_o is a pulse. rsp_level_o and rsp_id_o hold their last value between pulses.

Decomposition:
- fractal_sync_pkg: add the fsync_ccn_err_e enum (LVL, ID, DUP), the request struct {level,id} and the response struct.
- Sub-module fractal_sync_fifo: generic valid/ready FIFO with full/empty, synchronous active-high reset, instantiated N_IN_PORTS times.
- RR arbiter and RF stay in this module.

Test Plan:
1. Reset then idle: all outputs 0 except req_ready_o=2'b11. Holding rst_i=1 for 1 cycle while FIFOs are non-empty leaves them empty afterwards.
2. Local barrier: port0 and port1 send {lvl1,id3} at cycles 0 and 1. Expect rsp_valid_o pulse at cycle 3 with id=3, RF[3]=0 afterwards, up_req_valid_o=0 throughout.
3. Forward with backpressure: port1 sends {lvl2,id5} and up_req_ready_i=0 for 4 cycles. up_req_valid_o holds id=5 steady. A second port0 lvl2 request stays in its FIFO until the handshake completes.
4. Duplicate and bad id:
   - port0 sends {lvl1,id2} twice: err_o with code 2, port 0, and no rsp.
   - port1 sends {lvl1,id9} with N_ROOT_REGS=8: err code 1.
5. Fairness and full: both FIFOs full with local requests for distinct ids. Grants alternate 0,1,0,1. req_ready_o deasserts when a FIFO is full and reasserts the cycle after its pop.
6. Parent response collision: up_rsp_valid_i {lvl2,id7} in the same cycle a head is pending. rsp_valid_o carries id7 next cycle, and the pending grant is delayed by exactly 1 cycle.
